// File: rtl/display_window.sv
// display_window: maps VGA xpos/ypos to a frame-buffer read address with a per-frame
// latched integer upscale (1x/2x/4x), compensates RAM read latency and emits VGA_RGB
// aligned with display_valid.
// Optional border around the image window: define DISPLAY_WINDOW_BORDER_EN.
module display_window #(
  parameter int unsigned      PIX_W      = 12,
  parameter int unsigned      W          = 200,
  parameter int unsigned      H          = 150,
  parameter int unsigned      STARTROW   = 0,
  parameter int unsigned      STARTCOL   = 0,
  parameter int unsigned      ADDR_W     = 15,
  parameter int unsigned      RAM_LAT    = 1,
  parameter logic [7:0]       SHOW_STATE = 8'h03,
  parameter int unsigned      BORDER_W   = 2,
  parameter logic [PIX_W-1:0] BORDER_RGB = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [7:0]        state,
  input  logic [1:0]        scale,
  input  logic [PIX_W-1:0]  pixel_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              display_valid,
  output logic [PIX_W-1:0]  VGA_RGB
);

  localparam logic [12:0] LP_COL0 = 13'(STARTCOL);
  localparam logic [12:0] LP_ROW0 = 13'(STARTROW);

  // Elaboration-time parameter legality
  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_ram_lat
    $error("display_window: RAM_LAT must be in 1..4");
  end
  if (W * H > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("display_window: W*H does not fit in ADDR_W bits");
  end
  if (BORDER_W > 255 || $bits(BORDER_RGB) != PIX_W) begin : g_bad_border
    $error("display_window: illegal border configuration");
  end

  logic [1:0]         r_scale_q;     // latched shift amount (0, 1 or 2)
  logic               w_origin;
  logic [1:0]         w_scale_dec;
  logic [1:0]         w_shift;
  logic [12:0]        w_x13;
  logic [12:0]        w_y13;
  logic [12:0]        w_x_hi;
  logic [12:0]        w_y_hi;
  logic               w_in_x;
  logic               w_in_y;
  logic               w_show;
  logic               w_in_win;
  logic [11:0]        w_rx;
  logic [11:0]        w_ry;
  logic               r_win0;
  logic [11:0]        r_rx0;
  logic [11:0]        r_ry0;
  logic [RAM_LAT-1:0] r_vld_sr;
  logic               w_vld_dly;

  assign w_origin    = (xpos == 12'd0) && (ypos == 12'd0);
  // Reserved encoding 11 behaves as 1x
  assign w_scale_dec = (scale == 2'b01) ? 2'd1 : (scale == 2'b10) ? 2'd2 : 2'd0;
  // Pixel (0,0) already uses the value being latched in the same cycle
  assign w_shift     = w_origin ? w_scale_dec : r_scale_q;

  // 13-bit bounds: 4x of a 12-bit-range window cannot overflow the comparison
  assign w_x13    = {1'b0, xpos};
  assign w_y13    = {1'b0, ypos};
  assign w_x_hi   = LP_COL0 + (13'(W) << w_shift);
  assign w_y_hi   = LP_ROW0 + (13'(H) << w_shift);
  assign w_in_x   = (w_x13 >= LP_COL0) && (w_x13 < w_x_hi);
  assign w_in_y   = (w_y13 >= LP_ROW0) && (w_y13 < w_y_hi);
  assign w_show   = (state == SHOW_STATE);
  assign w_in_win = w_in_x && w_in_y && w_show;
  assign w_rx     = 12'((w_x13 - LP_COL0) >> w_shift);
  assign w_ry     = 12'((w_y13 - LP_ROW0) >> w_shift);

  assign w_vld_dly = r_vld_sr[RAM_LAT-1];

`ifdef DISPLAY_WINDOW_BORDER_EN
  logic [13:0]        w_x14;
  logic [13:0]        w_y14;
  logic               w_bdr_x;
  logic               w_bdr_y;
  logic               w_bdr;
  logic               r_bdr0;
  logic               r_bdr1;
  logic [RAM_LAT-1:0] r_bdr_sr;

  // Outer box is the window grown by BORDER_W; unsigned coords clip it at 0
  assign w_x14   = {2'b00, xpos};
  assign w_y14   = {2'b00, ypos};
  assign w_bdr_x = (w_x14 + 14'(BORDER_W) >= 14'(STARTCOL)) &&
                   (w_x14 < {1'b0, w_x_hi} + 14'(BORDER_W));
  assign w_bdr_y = (w_y14 + 14'(BORDER_W) >= 14'(STARTROW)) &&
                   (w_y14 < {1'b0, w_y_hi} + 14'(BORDER_W));
  assign w_bdr   = w_show && w_bdr_x && w_bdr_y && !(w_in_x && w_in_y);

  // Border flag travels alongside the valid flag so colours line up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bdr0   <= 1'b0;
      r_bdr1   <= 1'b0;
      r_bdr_sr <= '0;
    end else begin
      r_bdr0   <= w_bdr;
      r_bdr1   <= r_bdr0;
      r_bdr_sr <= RAM_LAT'({r_bdr_sr, r_bdr1});
    end
  end
`endif

  // Scale is latched only at the frame origin so a change never tears the image
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scale_q <= 2'd0;
    end else if (w_origin) begin
      r_scale_q <= w_scale_dec;
    end
  end

  // Stage 0: window test and source coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win0 <= 1'b0;
      r_rx0  <= 12'd0;
      r_ry0  <= 12'd0;
    end else begin
      r_win0 <= w_in_win;
      r_rx0  <= w_rx;
      r_ry0  <= w_ry;
    end
  end

  // Stage 1: linear read address; held while outside the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_en   <= 1'b0;
    end else begin
      rd_en <= r_win0;
      if (r_win0) begin
        rd_addr <= ADDR_W'(32'(r_ry0) * W + 32'(r_rx0));
      end
    end
  end

  // Valid delay matching the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr <= RAM_LAT'({r_vld_sr, rd_en});
    end
  end

  // Output register: image pixel, border colour or black
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_RGB       <= '0;
      display_valid <= 1'b0;
    end else if (w_vld_dly) begin
      VGA_RGB       <= pixel_data;
      display_valid <= 1'b1;
    end else begin
`ifdef DISPLAY_WINDOW_BORDER_EN
      VGA_RGB       <= r_bdr_sr[RAM_LAT-1] ? BORDER_RGB : '0;
`else
      VGA_RGB       <= '0;
`endif
      display_valid <= 1'b0;
    end
  end

endmodule
